// File: rtl/huff_canon_enc_if.sv
// Table-load, stream-in and packed-word-out signals of the canonical Huffman encoder.
interface huff_canon_enc_if #(
  parameter int NSYM    = 10,
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 9,
  parameter int OUT_W   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(OUT_W + 1);

  logic             len_we;
  logic [SYM_W-1:0] len_sym;
  logic [LEN_W-1:0] len_val;
  logic             build_start;
  logic             tbl_ready;
  logic             tbl_err;
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_sym;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic [CNT_W-1:0] out_nbits;

  modport master (
    output len_we, len_sym, len_val, build_start, in_valid, in_sym, in_last, out_ready,
    input  tbl_ready, tbl_err, in_ready, out_valid, out_data, out_last, out_nbits
  );

  modport slave (
    input  len_we, len_sym, len_val, build_start, in_valid, in_sym, in_last, out_ready,
    output tbl_ready, tbl_err, in_ready, out_valid, out_data, out_last, out_nbits
  );
endinterface

// File: rtl/huff_canon_enc.sv
// Canonical Huffman encoder: builds codes from a length table, then packs a symbol stream MSB first.
// IDLE: table load | BUILD: one (length, symbol) pair per cycle | ENC: stream encoding
module huff_canon_enc #(
  parameter int NSYM    = 10,
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 9,
  parameter int OUT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  huff_canon_enc_if.slave  bus
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int CNT_W  = $clog2(OUT_W + 1);
  localparam int ACC_W  = OUT_W + MAX_LEN - 1;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int CODE_W = MAX_LEN + 2;

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_ENC} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_tbl_q [NSYM];
  logic [MAX_LEN-1:0] code_tbl_q [NSYM];
  logic [LEN_W-1:0]   l_q, l_d;
  logic [SYM_W-1:0]   s_q, s_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               err_q, err_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               flush_q, flush_d;
  logic               open_q, open_d;

  logic [LEN_W-1:0]   cur_len, sym_len;
  logic [MAX_LEN-1:0] sym_code;
  logic [CODE_W-1:0]  code_inc;
  logic [ACC_W-1:0]   placed;
  logic hit, over, code_we, sym_ok, in_rdy, out_vld, last_word, emit, accept, wr_ok;

  assign cur_len  = len_tbl_q[s_q];
  assign hit      = (state_q == S_BUILD) && (cur_len == l_q);
  assign over     = (code_q >> l_q) != '0;
  assign code_we  = hit && !over;
  assign code_inc = code_q + {{(CODE_W-1){1'b0}}, code_we};

  assign sym_ok   = {1'b0, bus.in_sym} < (SYM_W+1)'(NSYM);
  assign sym_len  = sym_ok ? len_tbl_q[bus.in_sym] : '0;
  // Mask keeps stale entries of an oversubscribed table from spilling above the code length
  assign sym_code = (sym_ok ? code_tbl_q[bus.in_sym] : '0) & MAX_LEN'((32'd1 << sym_len) - 32'd1);
  assign placed   = ACC_W'(sym_code) << (FILL_W'(ACC_W) - FILL_W'(sym_len));

  assign in_rdy    = (state_q == S_ENC) && (fill_q < FILL_W'(OUT_W)) && !flush_q;
  assign out_vld   = (state_q == S_ENC) && ((fill_q >= FILL_W'(OUT_W)) || flush_q);
  assign last_word = flush_q && (fill_q <= FILL_W'(OUT_W));
  assign emit      = out_vld && bus.out_ready;
  assign accept    = bus.in_valid && in_rdy;
  assign wr_ok     = bus.len_we && ({1'b0, bus.len_sym} < (SYM_W+1)'(NSYM)) &&
                     ((state_q == S_IDLE) ||
                      ((state_q == S_ENC) && (fill_q == '0) && !flush_q && !open_q && !accept));

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    s_d     = s_q;
    code_d  = code_q;
    err_d   = err_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    flush_d = flush_q;
    open_d  = open_q;
    if (wr_ok && (bus.len_val > LEN_W'(MAX_LEN))) err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.build_start) begin
          state_d = S_BUILD;
          err_d   = 1'b0;
          l_d     = LEN_W'(1);
          s_d     = '0;
          code_d  = '0;
        end
      end
      S_BUILD: begin
        if (hit && over) err_d = 1'b1;
        if ((l_q == LEN_W'(1)) && (cur_len > LEN_W'(MAX_LEN))) err_d = 1'b1;
        if (s_q == SYM_W'(NSYM - 1)) begin
          s_d    = '0;
          code_d = code_inc << 1;
          if (l_q == LEN_W'(MAX_LEN)) state_d = S_ENC;
          else                         l_d     = l_q + 1'b1;
        end else begin
          s_d    = s_q + 1'b1;
          code_d = code_inc;
        end
      end
      S_ENC: begin
        if (emit) begin
          acc_d  = acc_q << OUT_W;
          fill_d = fill_q - FILL_W'(OUT_W);
          if (last_word) begin
            acc_d   = '0;
            fill_d  = '0;
            flush_d = 1'b0;
          end
        end
        if (accept) begin
          if (sym_len == '0) begin
            err_d = 1'b1;
          end else begin
            acc_d  = acc_d | (placed >> fill_d);
            fill_d = fill_d + FILL_W'(sym_len);
          end
          flush_d = bus.in_last;
          open_d  = !bus.in_last;
        end
        if (wr_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      l_q     <= '0;
      s_q     <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      fill_q  <= '0;
      flush_q <= 1'b0;
      open_q  <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        len_tbl_q[i]  <= '0;
        code_tbl_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      s_q     <= s_d;
      code_q  <= code_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      flush_q <= flush_d;
      open_q  <= open_d;
      if (wr_ok)   len_tbl_q[bus.len_sym] <= bus.len_val;
      if (code_we) code_tbl_q[s_q]        <= code_q[MAX_LEN-1:0];
    end
  end

  assign bus.tbl_ready = (state_q == S_ENC);
  assign bus.tbl_err   = err_q;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = acc_q[ACC_W-1 -: OUT_W];
  assign bus.out_last  = out_vld && last_word;
  assign bus.out_nbits = !out_vld ? '0 : (last_word ? CNT_W'(fill_q) : CNT_W'(OUT_W));
endmodule

// File: tb/tb_huff_canon_enc.sv
// Scoreboard bench for huff_canon_enc: expected words queued at stimulus time, compared on output handshake.
module tb_huff_canon_enc;
  localparam int NSYM = 10, SYM_W = 4, MAX_LEN = 9, OUT_W = 16;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [4:0]       nbits;
    logic             last;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  huff_canon_enc_if #(.NSYM(NSYM), .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .OUT_W(OUT_W)) bus ();

  huff_canon_enc #(.NSYM(NSYM), .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  logic  model_bits[$];
  int    tbl_len[NSYM];
  int    code_m[NSYM];
  int    bl_count[MAX_LEN+1];
  int    next_code[MAX_LEN+1];
  bit    stall_en = 1'b0;
  bit    stalled  = 1'b0;
  word_t hold_w;
  word_t pop_w;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference codes via the bl_count/next_code construction
  function automatic void calc_codes();
    int c = 0;
    for (int l = 0; l <= MAX_LEN; l++) bl_count[l] = 0;
    for (int s = 0; s < NSYM; s++)
      if (tbl_len[s] > 0 && tbl_len[s] <= MAX_LEN) bl_count[tbl_len[s]]++;
    bl_count[0] = 0;
    for (int b = 1; b <= MAX_LEN; b++) begin
      c = (c + bl_count[b-1]) << 1;
      next_code[b] = c;
    end
    for (int s = 0; s < NSYM; s++) begin
      code_m[s] = 0;
      if (tbl_len[s] > 0 && tbl_len[s] <= MAX_LEN) begin
        code_m[s] = next_code[tbl_len[s]];
        next_code[tbl_len[s]]++;
      end
    end
  endfunction

  task automatic push_exp(input logic [OUT_W-1:0] d, input int nb, input logic last);
    word_t w;
    w.data = d; w.nbits = 5'(nb); w.last = last;
    exp_q.push_back(w);
  endtask

  task automatic model_chop(input bit last);
    logic [OUT_W-1:0] d;
    int n;
    while (model_bits.size() > OUT_W || (!last && model_bits.size() == OUT_W)) begin
      d = '0;
      for (int i = OUT_W-1; i >= 0; i--) d[i] = model_bits.pop_front();
      push_exp(d, OUT_W, 1'b0);
    end
    if (last) begin
      d = '0;
      n = model_bits.size();
      for (int i = 0; i < n; i++) d[OUT_W-1-i] = model_bits.pop_front();
      push_exp(d, n, 1'b1);
    end
  endtask

  task automatic send(input int sym, input bit last, input bit use_model);
    int   n = 0;
    logic rdy;
    if (use_model) begin
      for (int b = tbl_len[sym]-1; b >= 0; b--) model_bits.push_back(code_m[sym][b]);
      model_chop(last);
    end
    bus.in_valid = 1'b1;
    bus.in_sym   = SYM_W'(sym);
    bus.in_last  = last;
    forever begin
      @(negedge clk); rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      if (++n > 1000) begin
        chk_eq("in_ready_timeout", rdy, 1'b1);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic load_table();
    for (int s = 0; s < NSYM; s++) begin
      bus.len_we  = 1'b1;
      bus.len_sym = SYM_W'(s);
      bus.len_val = 4'(tbl_len[s]);
      @(posedge clk); #1;
    end
    bus.len_we = 1'b0;
  endtask

  task automatic build_table();
    calc_codes();
    bus.build_start = 1'b1;
    @(posedge clk); #1;
    bus.build_start = 1'b0;
    chk_eq("err_cleared", bus.tbl_err, 1'b0);
    repeat (NSYM*MAX_LEN - 1) @(posedge clk);
    #1 chk_eq("ready_early", bus.tbl_ready, 1'b0);
    @(posedge clk); #1;
    chk_eq("ready_latency", bus.tbl_ready, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk); n++;
    end
    #1 chk_eq("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk_eq({tag, "_tbl_ready"}, bus.tbl_ready, 1'b0);
    chk_eq({tag, "_tbl_err"},   bus.tbl_err,   1'b0);
    chk_eq({tag, "_in_ready"},  bus.in_ready,  1'b0);
    chk_eq({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk_eq({tag, "_out_data"},  bus.out_data,  '0);
    chk_eq({tag, "_out_last"},  bus.out_last,  1'b0);
    chk_eq({tag, "_out_nbits"}, bus.out_nbits, '0);
  endtask

  task automatic set_tbl(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    tbl_len = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk_eq("stall_valid", bus.out_valid, 1'b1);
        chk_eq("stall_data",  bus.out_data,  hold_w.data);
        chk_eq("stall_nbits", bus.out_nbits, hold_w.nbits);
        chk_eq("stall_last",  bus.out_last,  hold_w.last);
      end
      if (bus.out_valid && bus.out_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_word", exp_q.size(), 1);
        end else begin
          pop_w = exp_q.pop_front();
          chk_eq("out_data",  bus.out_data,  pop_w.data);
          chk_eq("out_nbits", bus.out_nbits, pop_w.nbits);
          chk_eq("out_last",  bus.out_last,  pop_w.last);
        end
      end else if (bus.out_valid) begin
        stalled      = 1'b1;
        hold_w.data  = bus.out_data;
        hold_w.nbits = bus.out_nbits;
        hold_w.last  = bus.out_last;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.len_we = 1'b0; bus.len_sym = '0; bus.len_val = '0; bus.build_start = 1'b0;
    bus.in_valid = 1'b0; bus.in_sym = '0; bus.in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    rst = 1'b0;

    // Small table, single short stream
    set_tbl(2, 1, 3, 3, 0, 0, 0, 0, 0, 0);
    load_table();
    build_table();
    chk_eq("t1_err", bus.tbl_err, 1'b0);
    push_exp(16'h5B80, 9, 1'b1);
    send(1, 0, 0); send(0, 0, 0); send(2, 0, 0); send(3, 1, 0);
    wait_drain();

    // Word boundary crossing on flush
    push_exp(16'hFFFF, 16, 1'b0);
    push_exp(16'hC000, 2, 1'b1);
    for (int i = 0; i < 6; i++) send(3, i == 5, 0);
    wait_drain();

    // Oversubscribed table, then recovery
    set_tbl(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    load_table();
    chk_eq("reload_idle", bus.tbl_ready, 1'b0);
    build_table();
    chk_eq("oversub_err", bus.tbl_err, 1'b1);
    set_tbl(2, 1, 3, 3, 0, 0, 0, 0, 0, 0);
    load_table();
    build_table();
    chk_eq("recover_err", bus.tbl_err, 1'b0);

    // Unused symbol as the whole stream
    push_exp(16'h0000, 0, 1'b1);
    send(5, 1, 0);
    wait_drain();
    chk_eq("unused_sym_err", bus.tbl_err, 1'b1);

    // Random stream with output stalls
    set_tbl(2, 3, 3, 3, 4, 4, 5, 5, 6, 6);
    load_table();
    build_table();
    stall_en = 1'b1;
    for (int i = 0; i < 200; i++) send($urandom_range(0, NSYM-1), i == 199, 1);
    wait_drain();
    stall_en = 1'b0;
    chk_eq("rand_err", bus.tbl_err, 1'b0);

    // Reset in the middle of BUILD
    bus.build_start = 1'b1;
    @(posedge clk); #1;
    bus.build_start = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rst_build");
    rst = 1'b0;

    // Reset in the middle of a stream
    set_tbl(2, 1, 3, 3, 0, 0, 0, 0, 0, 0);
    load_table();
    build_table();
    send(1, 0, 0); send(0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rst_stream");
    rst = 1'b0;

    load_table();
    build_table();
    push_exp(16'h5B80, 9, 1'b1);
    send(1, 0, 0); send(0, 0, 0); send(2, 0, 0); send(3, 1, 0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
